// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch (IF)
// and data access (DM). One transaction at a time, registered outputs,
// DM-priority with a fairness limit, and a timeout for unacknowledged accesses.
//
//   state  | meaning
//   IDLE   | no access in flight; requests are sampled and one is granted
//   BUS_IF | fetch on the memory bus, waiting for mem_ack_i or timeout
//   BUS_DM | data access on the memory bus, waiting for mem_ack_i or timeout
//   DONE   | ack/err pulse cycle; requester drops its req before next grant
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_DM  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [AW-1:0]     if_addr_i,
    output logic              if_ack_o,
    output logic              if_err_o,
    output logic [DW-1:0]     if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [DW/8-1:0]   dm_be_i,
    input  logic [AW-1:0]     dm_addr_i,
    input  logic [DW-1:0]     dm_wdata_i,
    output logic              dm_ack_o,
    output logic              dm_err_o,
    output logic [DW-1:0]     dm_rdata_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_sel_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int FW = $clog2(MAX_DM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS_IF, BUS_DM, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [FW-1:0]  fair_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           grant_if;
    logic           grant_dm;
    logic           timed_out;

    assign timed_out = (tmo_cnt == TW'(TIMEOUT));

    // Grant decision in IDLE: DM wins a tie until IF has waited MAX_DM grants.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            if (if_req_i && dm_req_i) begin
                if (fair_cnt == FW'(MAX_DM)) grant_if = 1'b1;
                else                         grant_dm = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end else if (dm_req_i) begin
                grant_dm = 1'b1;
            end
        end
    end

    // Next-state logic; stb is high exactly while in a BUS state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_if)      state_nxt = BUS_IF;
                else if (grant_dm) state_nxt = BUS_DM;
            end
            BUS_IF, BUS_DM: begin
                if (mem_ack_i || timed_out) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Registered bus, pulses, read data, fairness and timeout counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fair_cnt    <= '0;
            tmo_cnt     <= '0;
            mem_stb_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_sel_o   <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            if_err_o    <= 1'b0;
            if_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            dm_err_o    <= 1'b0;
            dm_rdata_o  <= '0;
        end else begin
            if_ack_o <= 1'b0;
            if_err_o <= 1'b0;
            dm_ack_o <= 1'b0;
            dm_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        mem_stb_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_sel_o   <= '1;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                        tmo_cnt     <= '0;
                        fair_cnt    <= '0;
                    end else if (grant_dm) begin
                        mem_stb_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_sel_o   <= dm_we_i ? dm_be_i : '1;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        tmo_cnt     <= '0;
                        // A tied DM grant implies fair_cnt < MAX_DM, so this saturates.
                        if (if_req_i) fair_cnt <= fair_cnt + 1'b1;
                    end
                end
                BUS_IF, BUS_DM: begin
                    if (mem_ack_i) begin
                        mem_stb_o <= 1'b0;
                        if (state == BUS_IF) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_rdata_i;
                        end else begin
                            dm_ack_o <= 1'b1;
                            if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
                        end
                    end else if (timed_out) begin
                        mem_stb_o <= 1'b0;
                        if (state == BUS_IF) if_err_o <= 1'b1;
                        else                 dm_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a rule-level model of grant order and timing.
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_DM  = 4;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [31:0]   if_addr_i;
    logic          if_ack_o, if_err_o;
    logic [31:0]   if_rdata_o;
    logic          dm_req_i, dm_we_i;
    logic [3:0]    dm_be_i;
    logic [31:0]   dm_addr_i, dm_wdata_i;
    logic          dm_ack_o, dm_err_o;
    logic [31:0]   dm_rdata_o;
    logic          mem_stb_o, mem_we_o;
    logic [3:0]    mem_sel_o;
    logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic          mem_ack_i;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_DM(MAX_DM), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
        .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o),
        .dm_err_o(dm_err_o), .dm_rdata_o(dm_rdata_o),
        .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    int fair_model;

    // Reference rule: DM wins ties unless IF has already waited MAX_DM DM grants.
    function automatic bit model_pick_if(input bit ir, input bit dr);
        bit g;
        if (ir && dr) g = (fair_model >= MAX_DM);
        else          g = ir;
        if (g)       fair_model = 0;
        else if (ir) fair_model = (fair_model < MAX_DM) ? fair_model + 1 : MAX_DM;
        return g;
    endfunction

    task automatic do_reset();
        rst = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_if_rdata = '0; exp_dm_rdata = '0; fair_model = 0;
    endtask

    // Memory responder: waits for stb, acks in cycle wcyc after stb rises
    // (never if wcyc is out of range), returns at the first ack/err pulse.
    task automatic serve(input int wcyc, input logic [31:0] rd, output bit ok,
                         output int lat, output logic [3:0] pulses, output logic stb_end,
                         output logic [31:0] addr, output logic we,
                         output logic [3:0] sel, output logic [31:0] wdata);
        bit done;
        ok = 1'b0; lat = -1; pulses = '0; stb_end = 1'b1;
        addr = '0; we = 1'b0; sel = '0; wdata = '0;
        for (int k = 0; k < 10 && !mem_stb_o; k++) @(negedge clk);
        if (mem_stb_o) begin
            addr = mem_addr_o; we = mem_we_o; sel = mem_sel_o; wdata = mem_wdata_o;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                mem_ack_i   = (c == wcyc);
                mem_rdata_i = (c == wcyc) ? rd : (32'hBAD0_0000 ^ 32'(c));
                @(negedge clk);
                mem_ack_i = 1'b0;
                if (if_ack_o || if_err_o || dm_ack_o || dm_err_o) begin
                    ok = 1'b1; lat = c + 1; done = 1'b1;
                    pulses  = {if_ack_o, if_err_o, dm_ack_o, dm_err_o};
                    stb_end = mem_stb_o;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o, if_ack_o, if_err_o,
             dm_ack_o, dm_err_o} !== '0) begin
            bad++; $display("FAIL reset_bus: got stb=%b we=%b sel=%h addr=%h wdata=%h want all 0",
                            mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o);
        end
        total++;
        if ({if_rdata_o, dm_rdata_o} !== 64'd0) begin
            bad++; $display("FAIL reset_rdata: got if=%h dm=%h want 0", if_rdata_o, dm_rdata_o);
        end
    endtask

    task automatic test_if_read();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        logic [31:0] rd = 32'h1234_5678;
        if_addr_i = 32'h0000_0040; if_req_i = 1'b1;
        serve(2, rd, ok, lat, p, se, a, we, sel, wd);
        if_req_i = 1'b0;
        exp_if_rdata = rd;
        total++;
        if (!ok || lat != 3 || p !== 4'b1000) begin
            bad++; $display("FAIL if_read_ack: got ok=%0d lat=%0d pulses=%b want 1 3 1000", ok, lat, p);
        end
        total++;
        if (if_rdata_o !== exp_if_rdata) begin
            bad++; $display("FAIL if_read_rdata: got %h want %h", if_rdata_o, exp_if_rdata);
        end
        total++;
        if (we !== 1'b0 || sel !== 4'hF || a !== 32'h40) begin
            bad++; $display("FAIL if_read_bus: got we=%b sel=%h addr=%h want 0 f 40", we, sel, a);
        end
        @(negedge clk);
        total++;
        if (if_ack_o !== 1'b0 || mem_stb_o !== 1'b0) begin
            bad++; $display("FAIL if_read_single: got ack=%b stb=%b want 0 0", if_ack_o, mem_stb_o);
        end
    endtask

    task automatic test_dm_write();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        dm_addr_i = 32'h100; dm_be_i = 4'b0011; dm_wdata_i = 32'hDEAD_BEEF; dm_we_i = 1'b1;
        dm_req_i = 1'b1;
        serve(1, 32'hCAFE_F00D, ok, lat, p, se, a, we, sel, wd);
        dm_req_i = 1'b0;
        total++;
        if (a !== 32'h100 || we !== 1'b1 || sel !== 4'b0011 || wd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL dm_write_bus: got addr=%h we=%b sel=%b wdata=%h want 100 1 0011 deadbeef",
                            a, we, sel, wd);
        end
        total++;
        if (!ok || lat != 2 || p !== 4'b0010 || se !== 1'b0) begin
            bad++; $display("FAIL dm_write_ack: got ok=%0d lat=%0d pulses=%b stb=%b want 1 2 0010 0",
                            ok, lat, p, se);
        end
        total++;
        if (dm_rdata_o !== exp_dm_rdata) begin
            bad++; $display("FAIL dm_write_rdata: got %h want %h", dm_rdata_o, exp_dm_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        bit got_if, want_if;
        do_reset();
        if_addr_i = 32'h0000_0200; dm_addr_i = 32'h8000_0300; dm_we_i = 1'b0;
        if_req_i = 1'b1; dm_req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve(0, 32'(i), ok, lat, p, se, a, we, sel, wd);
            got_if  = (a == 32'h0000_0200);
            want_if = (i % 5 == 4);
            total++;
            if (!ok || got_if != want_if || p !== (want_if ? 4'b1000 : 4'b0010)) begin
                bad++; $display("FAIL fairness_order[%0d]: got if=%0d pulses=%b want if=%0d", i, got_if, p, want_if);
            end
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        do_reset();
        dm_addr_i = 32'h8000_0010; dm_we_i = 1'b0; dm_req_i = 1'b1;
        serve(100, 32'h0, ok, lat, p, se, a, we, sel, wd);
        dm_req_i = 1'b0;
        total++;
        if (!ok || lat != TIMEOUT + 1 || p !== 4'b0001 || se !== 1'b0) begin
            bad++; $display("FAIL timeout_err: got ok=%0d lat=%0d pulses=%b stb=%b want 1 16 0001 0", ok, lat, p, se);
        end
        total++;
        if (dm_rdata_o !== exp_dm_rdata) begin
            bad++; $display("FAIL timeout_rdata: got %h want %h", dm_rdata_o, exp_dm_rdata);
        end
        @(negedge clk);
        if_addr_i = 32'h0000_0500; if_req_i = 1'b1;
        serve(1, 32'h5555_AAAA, ok, lat, p, se, a, we, sel, wd);
        if_req_i = 1'b0;
        total++;
        if (!ok || lat != 2 || p !== 4'b1000 || if_rdata_o !== 32'h5555_AAAA) begin
            bad++; $display("FAIL timeout_then_if: got ok=%0d lat=%0d pulses=%b rdata=%h want 1 2 1000 5555aaaa",
                            ok, lat, p, if_rdata_o);
        end
        @(negedge clk);
    endtask

    task automatic test_ack_at_timeout();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        dm_addr_i = 32'h8000_0020; dm_we_i = 1'b0; dm_req_i = 1'b1;
        serve(TIMEOUT, 32'h0F0F_1234, ok, lat, p, se, a, we, sel, wd);
        dm_req_i = 1'b0;
        total++;
        if (!ok || lat != TIMEOUT + 1 || p !== 4'b0010 || dm_rdata_o !== 32'h0F0F_1234) begin
            bad++; $display("FAIL ack_at_timeout: got ok=%0d lat=%0d pulses=%b rdata=%h want 1 16 0010 0f0f1234",
                            ok, lat, p, dm_rdata_o);
        end
        exp_dm_rdata = 32'h0F0F_1234;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [3:0] seen;
        logic stb_seen;
        if_addr_i = 32'h0000_0700; if_req_i = 1'b1;
        for (int k = 0; k < 10 && !mem_stb_o; k++) @(negedge clk);
        total++;
        if (mem_stb_o !== 1'b1) begin
            bad++; $display("FAIL abort_stb_start: got stb=%b want 1", mem_stb_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1; if_req_i = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_stb_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o, if_ack_o, if_err_o, if_rdata_o,
             dm_ack_o, dm_err_o, dm_rdata_o} !== '0) begin
            bad++; $display("FAIL abort_outputs: got stb=%b addr=%h if_rdata=%h dm_rdata=%h want all 0",
                            mem_stb_o, mem_addr_o, if_rdata_o, dm_rdata_o);
        end
        rst = 1'b0; exp_if_rdata = '0; exp_dm_rdata = '0; fair_model = 0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        seen = '0; stb_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            seen = seen | {if_ack_o, if_err_o, dm_ack_o, dm_err_o};
            stb_seen = stb_seen | mem_stb_o;
        end
        total++;
        if (seen !== 4'b0000 || stb_seen !== 1'b0 || if_rdata_o !== 32'd0) begin
            bad++; $display("FAIL abort_late_ack: got pulses=%b stb=%b if_rdata=%h want 0000 0 0",
                            seen, stb_seen, if_rdata_o);
        end
    endtask

    task automatic test_random();
        bit ok; int lat; logic [3:0] p; logic se, we; logic [31:0] a, wd; logic [3:0] sel;
        bit ir, dr, dwe, exp_if; int w; logic [31:0] ia, da, dwd, rd; logic [3:0] be;
        logic [3:0] exp_p; int exp_lat; bit acked;
        for (int r = 0; r < 40; r++) begin
            ir  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            ia  = {1'b0, 31'($urandom)};
            da  = {1'b1, 31'($urandom)};
            dwe = 1'($urandom_range(0, 1));
            be  = 4'($urandom_range(1, 15));
            dwd = $urandom; rd = $urandom;
            w   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 15));
            if_addr_i = ia; dm_addr_i = da; dm_we_i = dwe; dm_be_i = be; dm_wdata_i = dwd;
            if_req_i = ir; dm_req_i = dr;
            exp_if  = model_pick_if(ir, dr);
            acked   = (w <= TIMEOUT);
            exp_lat = acked ? w + 1 : TIMEOUT + 1;
            if (exp_if) exp_p = acked ? 4'b1000 : 4'b0100;
            else        exp_p = acked ? 4'b0010 : 4'b0001;
            serve(w, rd, ok, lat, p, se, a, we, sel, wd);
            if_req_i = 1'b0; dm_req_i = 1'b0;
            if (acked && exp_if)         exp_if_rdata = rd;
            if (acked && !exp_if && !dwe) exp_dm_rdata = rd;
            total++;
            if (!ok || a !== (exp_if ? ia : da) || lat != exp_lat || p !== exp_p || se !== 1'b0) begin
                bad++; $display("FAIL random_txn[%0d]: got ok=%0d addr=%h lat=%0d pulses=%b want addr=%h lat=%0d pulses=%b",
                                r, ok, a, lat, p, exp_if ? ia : da, exp_lat, exp_p);
            end
            total++;
            if (exp_if ? (we !== 1'b0 || sel !== 4'hF)
                       : (we !== dwe || sel !== (dwe ? be : 4'hF) || (dwe && wd !== dwd))) begin
                bad++; $display("FAIL random_bus[%0d]: got we=%b sel=%h wdata=%h want we=%b be=%h wdata=%h",
                                r, we, sel, wd, exp_if ? 1'b0 : dwe, be, dwd);
            end
            total++;
            if (if_rdata_o !== exp_if_rdata || dm_rdata_o !== exp_dm_rdata) begin
                bad++; $display("FAIL random_rdata[%0d]: got if=%h dm=%h want if=%h dm=%h",
                                r, if_rdata_o, dm_rdata_o, exp_if_rdata, exp_dm_rdata);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
        dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        test_reset();
        test_if_read();
        test_dm_write();
        test_fairness();
        test_timeout();
        test_ack_at_timeout();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
